custom_bus_slave: RTL
=====================

// Module: custom_bus_slave
// PURPOSE
//  Responder end of the custom bus: answers custom_bus_master write and read transactions.
//  Bus writes land in an internal RX FIFO drained by local logic; bus reads return one word
//  from a local valid/ready source. Flow control by delaying s_ack (FIFO full / no read data).
// PARAMETERS
//  DEPTH        4   RX FIFO entries (power of 2, >=2)
//  WAIT_CYCLES  0   extra cycles before s_ack, counted in WR_WAIT/RD_WAIT (0..15)
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        reset, asynchronous, active-high
//  m_req         in   1        master request pulse (one cycle)
//  m_r0_w1       in   1        direction, valid only while m_req=1: 0 read, 1 write
//  m_wr_data     in   8        write data, valid the one cycle after s_ack on a write
//  m_done        in   1        master completion pulse
//  m_rd_data     out  8        read data to master, valid while s_ack=1 in RD_ACK
//  s_ack         out  1        request acknowledge (write) / read response strobe
//  s_data_ack    out  1        write data acknowledge
//  rx_data       out  8        head of RX FIFO (valid when rx_valid)
//  rx_valid      out  1        RX FIFO not empty
//  rx_pop        in   1        local pop; ignored when rx_valid=0
//  rx_count      out  $clog2(DEPTH)+1  RX FIFO occupancy
//  rd_src_data   in   8        local read data
//  rd_src_valid  in   1        local read data available
//  rd_src_ready  out  1        one-cycle pulse: rd_src_data consumed
//  proto_err     out  1        sticky: m_req=1 seen outside IDLE
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, wait counter 0; all outputs 0 (m_rd_data=0, rx_count=0).
//  Reset mid-transaction aborts it; FIFO contents lost; no partial push.
//  FSM (Moore outputs, registered state):
//   IDLE    : m_req&m_r0_w1 -> WR_WAIT; m_req&!m_r0_w1 -> RD_WAIT; counter cleared.
//   WR_WAIT : count++; when count>=WAIT_CYCLES and rx_count<DEPTH -> WR_ACK.
//   WR_ACK  : s_ack=1 (one cycle) -> WR_DATA.
//   WR_DATA : m_wr_data pushed into FIFO at end of this cycle -> WR_DACK.
//   WR_DACK : s_data_ack=1 (one cycle) -> DONE.
//   RD_WAIT : count++; when count>=WAIT_CYCLES and rd_src_valid -> RD_ACK;
//             on that edge m_rd_data<=rd_src_data; rd_src_ready=1 in this final RD_WAIT cycle.
//   RD_ACK  : s_ack=1, m_rd_data held (one cycle) -> DONE.
//   DONE    : m_done=1 -> IDLE; else stay.
//  m_rd_data returns to 0 on leaving RD_ACK.
//  Min latency req cycle -> s_ack: 2 cycles (WAIT_CYCLES=0, space/data available).
//  Write: full FIFO holds WR_WAIT; space checked only there (only this FSM pushes, so the slot
//   stays reserved). Pop-while-waiting frees space; s_ack the next cycle.
//  FIFO: push+pop same cycle -> count unchanged, both take effect; pop on empty ignored;
//   pointers wrap modulo DEPTH; rx_data shows head combinationally from storage.
//  Read with rd_src_valid=0 stalls in RD_WAIT indefinitely (master waits on s_ack).
//  proto_err set when m_req=1 in any state but IDLE; request ignored; cleared only by rst.
//  m_done in any state but DONE ignored. s_ack and s_data_ack never both 1.
// TESTING
//  1 Write 0xA5, WAIT=0, FIFO empty -> s_ack 2 cyc after req, 0xA5 pushed, s_data_ack, rx_count=1, rx_data=0xA5.
//  2 Read, rd_src_valid=1 data 0x3C -> rd_src_ready pulse, s_ack with m_rd_data=0x3C, master rd_data=0x3C.
//  3 Fill FIFO with DEPTH writes, 5th write -> s_ack held 0 until rx_pop, then acked; order preserved.
//  4 Read with rd_src_valid=0 for 10 cycles -> no s_ack; assert valid=0x77 -> s_ack, 0x77 returned.
//  5 WAIT_CYCLES=3, back-to-back write/read -> s_ack 5 cyc after each req; proto_err stays 0.
//  6 Assert rst during WR_DATA -> outputs 0, rx_count=0, next write completes normally.

Source files
------------

// File: rtl/custom_bus_slave_if.sv
// Custom bus link between a custom_bus_master and a custom_bus_slave.
//  m_req      : master request pulse (one cycle)
//  m_r0_w1    : direction while m_req=1 (0 read, 1 write)
//  m_wr_data  : write data, driven the cycle after s_ack on a write
//  m_done     : master completion pulse
//  m_rd_data  : read data from the slave, valid while s_ack=1 on a read
//  s_ack      : request acknowledge (write) / read response strobe
//  s_data_ack : write data acknowledge
interface custom_bus_slave_if;
    logic       m_req;
    logic       m_r0_w1;
    logic [7:0] m_wr_data;
    logic       m_done;
    logic [7:0] m_rd_data;
    logic       s_ack;
    logic       s_data_ack;

    modport master (
        output m_req, m_r0_w1, m_wr_data, m_done,
        input  m_rd_data, s_ack, s_data_ack
    );

    modport slave (
        input  m_req, m_r0_w1, m_wr_data, m_done,
        output m_rd_data, s_ack, s_data_ack
    );
endinterface

// File: rtl/custom_bus_slave.sv
// Responder end of the custom bus. Bus writes are pushed into an RX FIFO that
// local logic drains; bus reads return one word taken from a local valid/ready
// source. Flow control is done purely by delaying s_ack.
// Ports:
//  clk, rst         clock (rising edge), asynchronous active-high reset
//  bus              custom bus, slave side
//  rx_data/rx_valid RX FIFO head and not-empty flag
//  rx_pop           local pop, ignored when the FIFO is empty
//  rx_count         RX FIFO occupancy
//  rd_src_data/rd_src_valid/rd_src_ready  local read source handshake
//  proto_err        sticky flag: a request arrived while a transaction was open
module custom_bus_slave #(
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    custom_bus_slave_if.slave      bus,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    input  logic                   rx_pop,
    output logic [$clog2(DEPTH):0] rx_count,
    input  logic [7:0]             rd_src_data,
    input  logic                   rd_src_valid,
    output logic                   rd_src_ready,
    output logic                   proto_err
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, WR_WAIT, WR_ACK, WR_DATA, WR_DACK, RD_WAIT, RD_ACK, DONE
    } state_t;

    state_t        state_reg;
    logic [3:0]    wait_cnt_reg;
    logic          s_ack_reg;
    logic          s_data_ack_reg;
    logic [7:0]    m_rd_data_reg;
    logic          proto_err_reg;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic          wait_done;
    logic          push_fire;
    logic          pop_fire;
    logic          space_ok;

    // The counter saturates at WAIT_CYCLES so an indefinite stall cannot wrap it.
    assign wait_done = (wait_cnt_reg >= WAIT_L);
    assign push_fire = (state_reg == WR_DATA);
    assign pop_fire  = rx_pop && (count_reg != '0);
    // A pop in the same cycle frees a slot at this edge, so the write may be
    // acknowledged straight away. The slot stays reserved because only this
    // FSM pushes.
    assign space_ok  = (count_reg < DEPTH_L) || pop_fire;

    // rd_src_ready must coincide with the cycle the data is captured.
    assign rd_src_ready = (state_reg == RD_WAIT) && wait_done && rd_src_valid;

    assign bus.s_ack      = s_ack_reg;
    assign bus.s_data_ack = s_data_ack_reg;
    assign bus.m_rd_data  = m_rd_data_reg;
    assign proto_err      = proto_err_reg;

    assign rx_count = count_reg;
    assign rx_valid = (count_reg != '0);
    assign rx_data  = rx_valid ? mem[rd_ptr_reg] : 8'h00;

    // Transaction FSM; the ack strobes are set on entry to their states so they
    // are registered and last exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            s_ack_reg      <= 1'b0;
            s_data_ack_reg <= 1'b0;
            m_rd_data_reg  <= 8'h00;
            proto_err_reg  <= 1'b0;
        end else begin
            s_ack_reg      <= 1'b0;
            s_data_ack_reg <= 1'b0;
            if (bus.m_req && (state_reg != IDLE)) begin
                proto_err_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    wait_cnt_reg <= '0;
                    if (bus.m_req) begin
                        state_reg <= bus.m_r0_w1 ? WR_WAIT : RD_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (wait_done && space_ok) begin
                        state_reg <= WR_ACK;
                        s_ack_reg <= 1'b1;
                    end else if (!wait_done) begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                WR_ACK: begin
                    state_reg <= WR_DATA;
                end
                WR_DATA: begin
                    state_reg      <= WR_DACK;
                    s_data_ack_reg <= 1'b1;
                end
                WR_DACK: begin
                    state_reg <= DONE;
                end
                RD_WAIT: begin
                    if (wait_done && rd_src_valid) begin
                        state_reg     <= RD_ACK;
                        s_ack_reg     <= 1'b1;
                        m_rd_data_reg <= rd_src_data;
                    end else if (!wait_done) begin
                        wait_cnt_reg <= wait_cnt_reg + 4'd1;
                    end
                end
                RD_ACK: begin
                    state_reg     <= DONE;
                    m_rd_data_reg <= 8'h00;
                end
                DONE: begin
                    if (bus.m_done) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Storage has no reset: clearing the pointers is enough to discard contents.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg] <= bus.m_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule
